// File: rtl/mult8_nibble_seq_if.sv
// ============================================================================
// Module      : mult8_nibble_seq_if
// Description : Request/result handshake bundle for mult8_nibble_seq.
//               master = requester/consumer side, slave = sequencer side.
//   Request : in_valid, in_ready, in_a[7:0], in_b[7:0], in_tag[TAG_W-1:0]
//   Result  : out_valid, out_ready, out_p[15:0], out_tag[TAG_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult8_nibble_seq_if #(
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_p;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag
    );
endinterface

`default_nettype wire

// File: rtl/mult8_nibble_seq.sv
// ============================================================================
// Module      : mult8_nibble_seq
// Description : 8x8 -> 16-bit multiplier sequencer that time-multiplexes one
//               external 4x4 combinational multiplier over four nibble
//               partial products (4 cycles of MUL per request).
// Ports       : clk, rst_n (async, active low)
//               bus      - mult8_nibble_seq_if.slave request/result handshake
//               busy     - high while in MUL or DONE
//               core_a/b - registered nibble operands to the 4x4 core
//               core_p   - combinational 8-bit product from the 4x4 core
// Option      : define MULT8_NIBBLE_SEQ_SIGNED_EN for two's complement
//               operands (magnitudes multiplied, sign applied at the end).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult8_nibble_seq #(
    parameter int TAG_W = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    mult8_nibble_seq_if.slave       bus,
    output logic                    busy,
    output logic [3:0]              core_a,
    output logic [3:0]              core_b,
    input  wire logic [7:0]         core_p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       s;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic [TAG_W-1:0] tag_hold;
    logic [15:0]      acc;
    logic [15:0]      prod;
    logic [TAG_W-1:0] prod_tag;

    logic [7:0]       a_mag;
    logic [7:0]       b_mag;
    logic [3:0]       shift;
    logic [15:0]      term;
    logic [15:0]      acc_sum;
    logic [15:0]      final_p;
    logic [1:0]       s_next;
    logic [3:0]       next_a;
    logic [3:0]       next_b;

`ifdef MULT8_NIBBLE_SEQ_SIGNED_EN
    logic             neg;

    // 8'd0 - 8'h80 wraps to 8'h80, which is the required |-128| magnitude.
    assign a_mag   = bus.in_a[7] ? (8'd0 - bus.in_a) : bus.in_a;
    assign b_mag   = bus.in_b[7] ? (8'd0 - bus.in_b) : bus.in_b;
    assign final_p = neg ? (16'd0 - acc_sum) : acc_sum;
`else
    assign a_mag   = bus.in_a;
    assign b_mag   = bus.in_b;
    assign final_p = acc_sum;
`endif

    // Step s selects A nibble by s[0] and B nibble by s[1]; the shift is
    // 4 * (number of high nibbles involved): 0, 4, 4, 8.
    assign shift   = {s[0] & s[1], s[0] ^ s[1], 2'b00};
    assign term    = {8'b0, core_p} << shift;
    assign acc_sum = acc + term;

    // Core operands are registered, so they are loaded one cycle ahead with
    // the nibbles of the step that follows.
    assign s_next  = s + 2'd1;
    assign next_a  = s_next[0] ? op_a[7:4] : op_a[3:0];
    assign next_b  = s_next[1] ? op_b[7:4] : op_b[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s        <= 2'd0;
            op_a     <= 8'd0;
            op_b     <= 8'd0;
            tag_hold <= '0;
            acc      <= 16'd0;
            prod     <= 16'd0;
            prod_tag <= '0;
            core_a   <= 4'd0;
            core_b   <= 4'd0;
`ifdef MULT8_NIBBLE_SEQ_SIGNED_EN
            neg      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a     <= a_mag;
                        op_b     <= b_mag;
                        tag_hold <= bus.in_tag;
                        acc      <= 16'd0;
                        s        <= 2'd0;
                        core_a   <= a_mag[3:0];
                        core_b   <= b_mag[3:0];
`ifdef MULT8_NIBBLE_SEQ_SIGNED_EN
                        neg      <= bus.in_a[7] ^ bus.in_b[7];
`endif
                        state    <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc_sum;
                    s   <= s_next;
                    if (s == 2'd3) begin
                        prod     <= final_p;
                        prod_tag <= tag_hold;
                        core_a   <= 4'd0;
                        core_b   <= 4'd0;
                        state    <= DONE;
                    end else begin
                        core_a   <= next_a;
                        core_b   <= next_b;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode registered state only.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign busy          = (state == MUL) || (state == DONE);
    assign bus.out_p     = prod;
    assign bus.out_tag   = prod_tag;

endmodule

`default_nettype wire
